// File: rtl/cache_ctrl_2way_if.sv
// Bus between the memory stage / cache ways / banked memory and the 2-way cache controller.
interface cache_ctrl_2way_if #(
  parameter int WPL = 4
);
  localparam int OFFW = $clog2(WPL) + 1;

  // request side and cache/memory status
  logic            rd;
  logic            wr;
  logic [OFFW-1:0] offset;
  logic [1:0]      hit;
  logic [1:0]      valid;
  logic [1:0]      dirty;
  logic            lru;
  logic [3:0]      busy;

  // controller outputs
  logic [1:0]      enable;
  logic            comp;
  logic            write;
  logic            valid_in;
  logic            mem_wr;
  logic            mem_rd;
  logic [OFFW-2:0] word_m;
  logic [OFFW-2:0] word_c;
  logic            lru_we;
  logic            lru_val;
  logic            cache_hit;
  logic            done;
  logic            stall_out;
  logic            err;

  modport slave (
    input  rd, wr, offset, hit, valid, dirty, lru, busy,
    output enable, comp, write, valid_in, mem_wr, mem_rd, word_m, word_c,
           lru_we, lru_val, cache_hit, done, stall_out, err
  );

  modport master (
    output rd, wr, offset, hit, valid, dirty, lru, busy,
    input  enable, comp, write, valid_in, mem_wr, mem_rd, word_m, word_c,
           lru_we, lru_val, cache_hit, done, stall_out, err
  );
endinterface

// File: rtl/cache_ctrl_2way.sv
// Controller FSM for a 2-way set-associative write-back/write-allocate cache:
// compare in IDLE, optional dirty-victim eviction, pipelined line fill, retry.
module cache_ctrl_2way #(
  parameter int WPL     = 4,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  cache_ctrl_2way_if.slave  bus
);
  localparam int OFFW = $clog2(WPL) + 1;
  localparam int WW   = OFFW - 1;
  localparam int CW   = $clog2(WPL + MEM_LAT + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WPL - 1);
  localparam logic [CW-1:0] N_WORDS   = CW'(WPL);
  localparam logic [CW-1:0] LAT       = CW'(MEM_LAT);
  localparam logic [CW-1:0] LAST_FILL = CW'(WPL + MEM_LAT - 1);

  typedef enum logic [2:0] {IDLE, EVICT, EVWAIT, FILL, RETRY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          victim_q, victim_d;
  logic          err_q, err_d;

  logic [1:0]    hv;
  logic [1:0]    vic_oh;
  logic          victim_sel;
  logic [CW-1:0] wcnt;
  logic          unused_offset_bit;

  assign hv                = bus.hit & bus.valid;
  assign vic_oh            = victim_q ? 2'b10 : 2'b01;
  assign wcnt              = cnt_q - LAT;
  assign unused_offset_bit = bus.offset[0];
  assign bus.err           = err_q;

  // victim choice on a miss: first invalid way (way0 first), otherwise the LRU way
  always_comb begin
    victim_sel = bus.lru;
    if (!bus.valid[0])      victim_sel = 1'b0;
    else if (!bus.valid[1]) victim_sel = 1'b1;
  end

  // state, counter, victim and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      victim_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      err_q    <= err_d;
    end
  end

  // next-state and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    victim_d      = victim_q;
    err_d         = err_q;
    bus.enable    = 2'b00;
    bus.comp      = 1'b0;
    bus.write     = 1'b0;
    bus.valid_in  = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.word_m    = '0;
    bus.word_c    = '0;
    bus.lru_we    = 1'b0;
    bus.lru_val   = 1'b0;
    bus.cache_hit = 1'b0;
    bus.done      = 1'b0;
    bus.stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.rd && bus.wr) begin
          err_d = 1'b1;
        end else if (bus.rd || bus.wr) begin
          bus.enable   = 2'b11;
          bus.comp     = 1'b1;
          bus.write    = bus.wr;
          bus.valid_in = bus.wr;
          bus.word_c   = bus.offset[OFFW-1:1];
          if (hv == 2'b11) err_d = 1'b1;
          if (|hv) begin
            bus.done      = 1'b1;
            bus.cache_hit = 1'b1;
            bus.lru_we    = 1'b1;
            bus.lru_val   = ~hv[1];
          end else begin
            bus.stall_out = 1'b1;
            victim_d      = victim_sel;
            state_d       = (bus.valid[victim_sel] && bus.dirty[victim_sel]) ? EVICT : FILL;
          end
        end
      end
      EVICT: begin
        // a busy bank holds the same word until it can be issued
        bus.stall_out = 1'b1;
        bus.enable    = vic_oh;
        bus.word_c    = cnt_q[WW-1:0];
        bus.word_m    = cnt_q[WW-1:0];
        if (!bus.busy[cnt_q[1:0]]) begin
          bus.mem_wr = 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = EVWAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVWAIT: begin
        bus.stall_out = 1'b1;
        if (bus.busy == 4'b0000) state_d = FILL;
      end
      FILL: begin
        // reads lead cache writes by MEM_LAT cycles; cnt_q is the read index
        bus.stall_out = 1'b1;
        if (cnt_q < N_WORDS) begin
          bus.mem_rd = 1'b1;
          bus.word_m = cnt_q[WW-1:0];
        end
        if (cnt_q >= LAT) begin
          bus.enable   = vic_oh;
          bus.write    = 1'b1;
          bus.valid_in = 1'b1;
          bus.word_c   = wcnt[WW-1:0];
        end
        if (cnt_q == LAST_FILL) begin
          cnt_d   = '0;
          state_d = RETRY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RETRY: begin
        bus.enable   = vic_oh;
        bus.comp     = 1'b1;
        bus.write    = bus.wr;
        bus.valid_in = 1'b1;
        bus.word_c   = bus.offset[OFFW-1:1];
        bus.done     = 1'b1;
        bus.lru_we   = 1'b1;
        bus.lru_val  = ~victim_q;
        if (!(|hv)) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Randomized self-checking bench for cache_ctrl_2way with an event-level reference model.
module tb_cache_ctrl_2way;
  parameter int WPL     = 4;
  parameter int MEM_LAT = 2;
  localparam int OFFW = $clog2(WPL) + 1;
  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cache_ctrl_2way_if #(.WPL(WPL)) bus ();
  cache_ctrl_2way #(.WPL(WPL), .MEM_LAT(MEM_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({bus.enable, bus.comp, bus.write, bus.valid_in, bus.mem_wr, bus.mem_rd,
                bus.word_m, bus.word_c, bus.lru_we, bus.lru_val, bus.cache_hit,
                bus.done, bus.stall_out, bus.err});
  endfunction

  function automatic logic [3:0] gen_busy(input int m, input int c);
    logic [3:0] b;
    b = 4'b0000;
    if (m == 1) begin
      for (int i = 0; i < 4; i++) b[i] = ($urandom_range(0, 3) == 0);
    end else if (m == 2) begin
      if (c >= 3 && c <= 5) b = 4'b0100;
    end
    return b;
  endfunction

  task automatic set_idle();
    bus.rd = 1'b0; bus.wr = 1'b0; bus.offset = '0; bus.hit = 2'b00;
    bus.valid = 2'b00; bus.dirty = 2'b00; bus.lru = 1'b0; bus.busy = 4'b0000;
  endtask

  // One access; entered and left at #1 after a rising edge.
  task automatic run_txn(input bit is_wr, input logic [OFFW-1:0] offs, input logic [1:0] h,
                         input logic [1:0] v, input logic [1:0] d, input bit l,
                         input int bmode, input bit exp_err);
    logic [1:0] hv, voh;
    logic [3:0] bh [MAXC];
    int wr_c[$], wr_w[$], rd_c[$], rd_w[$], cw_c[$], cw_w[$];
    int done_c, nrec, n_hit, n_ovl, n_stall, n_busy, n_en, t, fs, wm;
    int ewc [16];
    bit vic, evict;
    hv = h & v;
    vic = (!v[0]) ? 1'b0 : ((!v[1]) ? 1'b1 : l);
    voh = vic ? 2'b10 : 2'b01;
    evict = v[vic] & d[vic];
    done_c = -1; nrec = 0; n_hit = 0; n_ovl = 0; n_stall = 0; n_busy = 0; n_en = 0;
    bus.rd = !is_wr; bus.wr = is_wr; bus.offset = offs; bus.hit = h;
    bus.valid = v; bus.dirty = d; bus.lru = l;
    for (int c = 0; c < MAXC; c++) begin
      bus.busy = gen_busy(bmode, c);
      bh[c] = bus.busy;
      nrec = c + 1;
      @(negedge clk);
      if (c == 0) begin
        check_val("cmp_enable", 32'(bus.enable), 32'(2'b11));
        check_val("cmp_comp", 32'(bus.comp), 32'(1'b1));
        check_val("cmp_write", 32'(bus.write), 32'(is_wr));
        check_val("cmp_word_c", 32'(bus.word_c), 32'(offs[OFFW-1:1]));
        check_val("cmp_strobes", 32'({bus.mem_wr, bus.mem_rd}), 32'(2'b00));
        if (hv != 2'b00) begin
          check_val("hit_done", 32'({bus.done, bus.cache_hit, bus.stall_out}), 32'(3'b110));
          check_val("hit_lru", 32'({bus.lru_we, bus.lru_val}), 32'({1'b1, hv == 2'b01}));
          done_c = 0;
          break;
        end
        check_val("miss_stall", 32'({bus.done, bus.cache_hit, bus.stall_out}), 32'(3'b001));
      end else begin
        if (bus.cache_hit) n_hit++;
        if (bus.done && (bus.mem_wr || bus.mem_rd)) n_ovl++;
        if (bus.stall_out == bus.done) n_stall++;
        if (bus.mem_wr) begin
          wm = int'(bus.word_m);
          wr_c.push_back(c); wr_w.push_back(wm);
          if (bus.busy[wm % 4]) n_busy++;
          if (bus.enable != voh || bus.word_c != bus.word_m || bus.write) n_en++;
        end
        if (bus.mem_rd) begin rd_c.push_back(c); rd_w.push_back(int'(bus.word_m)); end
        if (bus.write && !bus.comp) begin
          cw_c.push_back(c); cw_w.push_back(int'(bus.word_c));
          if (bus.enable != voh || !bus.valid_in) n_en++;
        end
        if (bus.done) begin
          check_val("rt_ctrl", 32'({bus.enable, bus.comp, bus.write, bus.valid_in}),
                    32'({voh, 1'b1, is_wr, 1'b1}));
          check_val("rt_lru", 32'({bus.lru_we, bus.lru_val, bus.cache_hit}), 32'({1'b1, !vic, 1'b0}));
          check_val("rt_word_c", 32'(bus.word_c), 32'(offs[OFFW-1:1]));
          done_c = c;
          break;
        end
      end
      @(posedge clk); #1;
      if (c == 0) begin bus.hit = voh; bus.valid = v | voh; end
    end
    if (done_c < 0) begin
      check_val("timeout", 32'(0), 32'(1));
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end else if (hv == 2'b00) begin
      fs = 1; t = 1;
      if (evict) begin
        for (int k = 0; k < WPL; k++) begin
          while (t < nrec && bh[t][k % 4]) t++;
          ewc[k] = t; t++;
        end
        while (t < nrec && bh[t] != 4'b0000) t++;
        fs = t + 1;
      end
      check_val("ev_count", 32'(wr_c.size()), 32'(evict ? WPL : 0));
      for (int k = 0; k < wr_c.size() && k < WPL && evict; k++) begin
        check_val("ev_cycle", 32'(wr_c[k]), 32'(ewc[k]));
        check_val("ev_word", 32'(wr_w[k]), 32'(k));
      end
      check_val("rd_count", 32'(rd_c.size()), 32'(WPL));
      for (int j = 0; j < rd_c.size() && j < WPL; j++) begin
        check_val("rd_cycle", 32'(rd_c[j]), 32'(fs + j));
        check_val("rd_word", 32'(rd_w[j]), 32'(j));
      end
      check_val("cw_count", 32'(cw_c.size()), 32'(WPL));
      for (int j = 0; j < cw_c.size() && j < WPL; j++) begin
        check_val("cw_cycle", 32'(cw_c[j]), 32'(fs + MEM_LAT + j));
        check_val("cw_word", 32'(cw_w[j]), 32'(j));
      end
      check_val("done_cycle", 32'(done_c), 32'(fs + WPL + MEM_LAT));
      check_val("inv_counts", 32'({8'(n_hit), 8'(n_ovl), 8'(n_stall), 4'(n_busy), 4'(n_en)}), 32'(0));
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check_val("err_state", 32'(bus.err), 32'(exp_err));
    $display("txn wr=%0d h=%b v=%b d=%b l=%0d victim=%0d evict=%0d done_at=%0d",
             is_wr, h, v, d, l, vic, evict, done_c);
    @(posedge clk); #1;
  endtask

  // Random access with no double-way hit.
  task automatic rand_txn(input bit exp_err);
    logic [1:0] h, v, d;
    v = 2'($urandom_range(0, 3));
    d = 2'($urandom_range(0, 3));
    h = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
    if ((h & v) == 2'b11) h = 2'b01;
    run_txn(1'($urandom_range(0, 1)), OFFW'($urandom_range(0, 2 * WPL - 1)), h, v, d,
            1'($urandom_range(0, 1)), 1, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_outs", outs_vec(), 32'(0));
    @(posedge clk); #1;

    // directed: way1 hit, clean fill into invalid way1, dirty eviction, busy bank hold
    run_txn(1'b0, OFFW'(5), 2'b10, 2'b11, 2'b00, 1'b0, 0, 1'b0);
    run_txn(1'b1, OFFW'(3), 2'b00, 2'b01, 2'b00, 1'b0, 0, 1'b0);
    run_txn(1'b0, OFFW'(2), 2'b00, 2'b11, 2'b01, 1'b0, 0, 1'b0);
    run_txn(1'b1, OFFW'(0), 2'b00, 2'b11, 2'b11, 1'b1, 2, 1'b0);

    for (int i = 0; i < 40; i++) rand_txn(1'b0);

    // reset in the second fill cycle aborts to IDLE
    bus.wr = 1'b1; bus.offset = OFFW'(1); bus.valid = 2'b01; bus.hit = 2'b00;
    @(posedge clk); #1;
    bus.hit = 2'b10; bus.valid = 2'b11;
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_mid_fill", outs_vec(), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_no_mem", 32'({bus.mem_wr, bus.mem_rd}), 32'(0));
    end
    @(posedge clk); #1;
    run_txn(1'b0, OFFW'(1), 2'b01, 2'b01, 2'b00, 1'b0, 0, 1'b0);

    // rd and wr together sets a sticky error
    bus.rd = 1'b1; bus.wr = 1'b1;
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check_val("err_set", 32'(bus.err), 32'(1));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rand_txn(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("err_cleared", 32'(bus.err), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
